// File: rtl/spi_reg_master.sv
// -----------------------------------------------------------------------------
// spi_reg_master
//
// SPI initiator for the chip's SPI register-bank slave. A one-shot request
// (start + rw/addr/wdata) becomes one 16-bit SPI frame:
//     {rw, zeros, addr, data}   MSB first
// where data is wdata for a write and all zeros for a read. The last eight
// bits sampled from spi_miso become rdata, and only a read updates rdata.
//
// Transaction timeline, with every phase a multiple of CLK_DIV clk cycles:
//     SETUP (1 x CLK_DIV)    : cs_n low, MOSI = frame bit 15
//     SHIFT (32 x CLK_DIV)   : 32 half-periods, spi_clk toggles at the end of each
//     HOLD  (1 x CLK_DIV)    : cs_n low, spi_clk at CPOL
//     GAP   (1 x CLK_DIV)    : cs_n high; busy drops and done pulses at the end
// If start is sampled at cycle N, done appears at cycle N + 35*CLK_DIV + 1.
//
// Parameters:
//     CLK_DIV    clk cycles per SPI half-period (>=2; >=6 for the on-chip slave)
//     ADDR_WIDTH register address width (<=6 so the frame keeps its zero pad)
//     REG_WIDTH  register data width
//
// Ports:
//     clk, rst           system clock and synchronous active-high reset
//     ena                global enable; when low, every register holds
//     mode               {cpol, cpha}; tracked only while idle
//     start              request strobe; accepted while idle and enabled
//     rw, addr, wdata    request fields, captured together with start
//     busy, done         transaction in progress / one-cycle completion pulse
//     rdata              last byte read
//     spi_cs_n, spi_clk, spi_mosi, spi_miso   SPI pins
// -----------------------------------------------------------------------------
module spi_reg_master #(
    parameter int CLK_DIV    = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    output logic                  busy,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int FRAME_W   = 8 + REG_WIDTH;
    localparam int NUM_EDGES = 2 * FRAME_W;
    localparam int EDGE_W    = $clog2(NUM_EDGES + 1);
    localparam int CNT_W     = $clog2(CLK_DIV);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]           state_r;
    logic [CNT_W-1:0]     div_cnt_r;
    logic [EDGE_W-1:0]    edge_cnt_r;
    logic [FRAME_W-1:0]   tx_sr_r;
    logic [REG_WIDTH-1:0] rx_sr_r;
    logic                 rw_r;
    logic [1:0]           mode_q_r;

    logic                 div_end_s;
    logic [EDGE_W-1:0]    edge_num_s;
    logic                 edge_odd_s;
    logic                 last_edge_s;
    logic [FRAME_W-1:0]   frame_s;

    // Assemble the outgoing frame; the data field is zeroed for reads.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic                  w,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [REG_WIDTH-1:0]  d
    );
        logic [FRAME_W-1:0] f;
        f = {FRAME_W{1'b0}};
        f[FRAME_W-1] = w;
        f[REG_WIDTH +: ADDR_WIDTH] = a;
        if (w) begin
            f[REG_WIDTH-1:0] = d;
        end else begin
            f[REG_WIDTH-1:0] = {REG_WIDTH{1'b0}};
        end
        return f;
    endfunction

    // Divider terminal count, SPI edge numbering (1-based) and the request frame.
    always_comb begin
        div_end_s   = (div_cnt_r == CNT_W'(CLK_DIV - 1));
        edge_num_s  = edge_cnt_r + EDGE_W'(1);
        edge_odd_s  = edge_num_s[0];
        last_edge_s = (edge_num_s == EDGE_W'(NUM_EDGES));
        frame_s     = build_frame(rw, addr, wdata);
    end

    // Transaction sequencer: divider, FSM, shift registers and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= {CNT_W{1'b0}};
            edge_cnt_r <= {EDGE_W{1'b0}};
            tx_sr_r    <= {FRAME_W{1'b0}};
            rx_sr_r    <= {REG_WIDTH{1'b0}};
            rw_r       <= 1'b0;
            mode_q_r   <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= {REG_WIDTH{1'b0}};
            spi_cs_n   <= 1'b1;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            // done is a single enabled-cycle pulse; it never stretches across a freeze.
            done <= 1'b0;
            if (ena) begin
                case (state_r)
                    ST_IDLE: begin
                        // Mode tracks the input only while idle, so mid-frame changes are ignored.
                        mode_q_r <= mode;
                        spi_clk  <= mode_q_r[1];
                        if (start) begin
                            state_r    <= ST_SETUP;
                            busy       <= 1'b1;
                            spi_cs_n   <= 1'b0;
                            tx_sr_r    <= frame_s;
                            spi_mosi   <= frame_s[FRAME_W-1];
                            rw_r       <= rw;
                            rx_sr_r    <= {REG_WIDTH{1'b0}};
                            div_cnt_r  <= {CNT_W{1'b0}};
                            edge_cnt_r <= {EDGE_W{1'b0}};
                        end
                    end

                    ST_SETUP: begin
                        // Re-assert CPOL in case mode changed on the very cycle start was taken.
                        spi_clk <= mode_q_r[1];
                        if (div_end_s) begin
                            div_cnt_r <= {CNT_W{1'b0}};
                            state_r   <= ST_SHIFT;
                        end else begin
                            div_cnt_r <= div_cnt_r + CNT_W'(1);
                        end
                    end

                    ST_SHIFT: begin
                        if (div_end_s) begin
                            div_cnt_r <= {CNT_W{1'b0}};
                            spi_clk   <= ~spi_clk;
                            if (mode_q_r[0] == 1'b0) begin
                                // CPHA=0: bit 15 is already on MOSI; sample on odd
                                // edges, advance MOSI on even edges except the last.
                                if (edge_odd_s) begin
                                    rx_sr_r <= {rx_sr_r[REG_WIDTH-2:0], spi_miso};
                                end else if (!last_edge_s) begin
                                    spi_mosi <= tx_sr_r[FRAME_W-2];
                                    tx_sr_r  <= {tx_sr_r[FRAME_W-2:0], 1'b0};
                                end
                            end else begin
                                // CPHA=1: drive the next bit on odd edges (edge 1 re-drives
                                // bit 15); sample on even edges.
                                if (edge_odd_s) begin
                                    spi_mosi <= tx_sr_r[FRAME_W-1];
                                    tx_sr_r  <= {tx_sr_r[FRAME_W-2:0], 1'b0};
                                end else begin
                                    rx_sr_r <= {rx_sr_r[REG_WIDTH-2:0], spi_miso};
                                end
                            end
                            if (last_edge_s) begin
                                edge_cnt_r <= {EDGE_W{1'b0}};
                                state_r    <= ST_HOLD;
                            end else begin
                                edge_cnt_r <= edge_num_s;
                            end
                        end else begin
                            div_cnt_r <= div_cnt_r + CNT_W'(1);
                        end
                    end

                    ST_HOLD: begin
                        if (div_end_s) begin
                            div_cnt_r <= {CNT_W{1'b0}};
                            spi_cs_n  <= 1'b1;
                            spi_mosi  <= 1'b0;
                            state_r   <= ST_GAP;
                        end else begin
                            div_cnt_r <= div_cnt_r + CNT_W'(1);
                        end
                    end

                    ST_GAP: begin
                        if (div_end_s) begin
                            div_cnt_r <= {CNT_W{1'b0}};
                            state_r   <= ST_IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            // Writes shift in don't-care data; keep the last read byte.
                            if (!rw_r) begin
                                rdata <= rx_sr_r;
                            end
                        end else begin
                            div_cnt_r <= div_cnt_r + CNT_W'(1);
                        end
                    end

                    default: begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        spi_cs_n  <= 1'b1;
                        spi_mosi  <= 1'b0;
                        div_cnt_r <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_master
//
// Directed bench for spi_reg_master (CLK_DIV=8). A behavioural register-bank
// slave sits on the SPI pins: it captures MOSI on the proper edges, returns
// the addressed register in the second byte, and commits complete writes.
// Each accepted request pushes its hand-computed expectation into a queue;
// a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_spi_reg_master;

    localparam int D   = 8;
    localparam int LAT = 35 * D + 1;

    logic       clk, rst, ena, start, rw;
    logic [1:0] mode;
    logic [2:0] addr;
    logic [7:0] wdata, rdata;
    logic       busy, done, spi_cs_n, spi_clk, spi_mosi, spi_miso;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
        int          lat;
        int          cs_low;
        time         t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t drop_e;
    int   checks = 0;
    int   errors = 0;

    spi_reg_master #(.CLK_DIV(D), .ADDR_WIDTH(3), .REG_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .mode     (mode),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural SPI register-bank slave ----------------
    logic [7:0]  sregs [0:7];
    logic [15:0] sl_cap, last_frame;
    logic [2:0]  sl_addr;
    int          sl_edges, sl_nb, sl_rises, sl_j;
    logic        sl_drive;

    initial begin
        for (int i = 0; i < 8; i++) sregs[i] = 8'h00;
        sregs[0]   = 8'hA5;
        sregs[7]   = 8'h3C;
        spi_miso   = 1'b0;
        sl_cap     = 16'h0000;
        last_frame = 16'h0000;
        sl_addr    = 3'd0;
        sl_edges   = 0;
        sl_nb      = 0;
        sl_rises   = 0;
    end

    always @(negedge spi_cs_n) begin
        sl_cap   = 16'h0000;
        sl_nb    = 0;
        sl_edges = 0;
        sl_rises = 0;
        spi_miso = 1'b0;
    end

    always @(spi_clk) begin
        if (spi_cs_n === 1'b0) begin
            sl_edges++;
            if (spi_clk === 1'b1) sl_rises++;
            if ((mode[0] == 1'b0 && (sl_edges % 2) == 1) || (mode[0] == 1'b1 && (sl_edges % 2) == 0)) begin
                sl_cap = {sl_cap[14:0], spi_mosi};
                sl_nb++;
                if (sl_nb == 8) sl_addr = sl_cap[2:0];
            end
            sl_drive = 1'b0;
            if (mode[0] == 1'b0 && (sl_edges % 2) == 0 && sl_edges <= 30) begin
                sl_j = sl_edges / 2;
                sl_drive = 1'b1;
            end
            if (mode[0] == 1'b1 && (sl_edges % 2) == 1) begin
                sl_j = (sl_edges - 1) / 2;
                sl_drive = 1'b1;
            end
            if (sl_drive) spi_miso = (sl_j >= 8) ? sregs[sl_addr][15 - sl_j] : 1'b0;
        end
    end

    always @(posedge spi_cs_n) begin
        last_frame = sl_cap;
        if (sl_nb == 16 && sl_cap[15]) sregs[sl_cap[10:8]] = sl_cap[7:0];
    end

    // ---------------- pin monitor: CS windows and MOSI edge rule ----------------
    logic p_clk, p_mosi, p_cs;
    int   cs_low, cs_high, gap_last, viol;

    initial begin
        p_clk = 1'b0; p_mosi = 1'b0; p_cs = 1'b1;
        cs_low = 0; cs_high = 0; gap_last = 0; viol = 0;
    end

    always @(negedge clk) begin
        if (spi_cs_n === 1'b0) begin
            if (p_cs) begin
                cs_low   = 1;
                viol     = 0;
                gap_last = cs_high;
            end else begin
                cs_low++;
                if (spi_mosi !== p_mosi) begin
                    // MOSI may move only with an SPI edge: leading for CPHA=1, trailing for CPHA=0.
                    if (spi_clk === p_clk) viol++;
                    else if ((spi_clk === mode[1]) == mode[0]) viol++;
                end
            end
        end else begin
            cs_high = p_cs ? cs_high + 1 : 1;
        end
        p_clk  = spi_clk;
        p_mosi = spi_mosi;
        p_cs   = (spi_cs_n !== 1'b0);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", rdata, mon_e.rd);
                chk("mosi_frame", last_frame, mon_e.frame);
                chk("latency", int'(($time - mon_e.t0 - 5) / 10) + 1, mon_e.lat);
                chk("cs_low_cycles", cs_low, mon_e.cs_low);
                chk("rising_edges", sl_rises, 16);
                chk("mosi_edge_rule", viol, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic r_w, input logic [2:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input int extra);
        exp_t e;
        rw    = r_w;
        addr  = a;
        wdata = d;
        start = 1'b1;
        @(posedge clk);
        e.frame  = {r_w, 4'b0000, a, (r_w ? d : 8'h00)};
        e.rd     = exp_rd;
        e.lat    = LAT + extra;
        e.cs_low = 34 * D + extra;
        e.t0     = $time;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("idle_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk("done_timeout", done, 1'b1);
    endtask

    logic [11:0] snap;

    initial begin
        rst = 1'b1; ena = 1'b1; mode = 2'b00; start = 1'b0;
        rw = 1'b0; addr = 3'd0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_spi_clk", spi_clk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0 write addr 2 <- 0x35: frame 0x8235, rdata stays 0.
        issue(1'b1, 3'd2, 8'h35, 8'h00, 0);
        wait_idle(400);

        // Mode 3 read addr 0: idle clock high, returns 0xA5, frame 0x0000.
        mode = 2'b11;
        repeat (4) @(negedge clk);
        chk("idle_clk_cpol1", spi_clk, 1'b1);
        issue(1'b0, 3'd0, 8'h00, 8'hA5, 0);
        wait_idle(400);

        // Modes 1 and 2 read addr 7: returns 0x3C, frame 0x0700.
        mode = 2'b01;
        repeat (4) @(negedge clk);
        issue(1'b0, 3'd7, 8'h00, 8'h3C, 0);
        wait_idle(400);
        mode = 2'b10;
        repeat (4) @(negedge clk);
        issue(1'b0, 3'd7, 8'h00, 8'h3C, 0);
        wait_idle(400);

        // Back-to-back: write addr 5, a dropped start mid-frame, read on the done cycle.
        mode = 2'b00;
        repeat (4) @(negedge clk);
        issue(1'b1, 3'd5, 8'h5A, 8'h3C, 0);
        repeat (100) @(negedge clk);
        rw = 1'b1; addr = 3'd6; wdata = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        issue(1'b0, 3'd5, 8'h00, 8'h5A, 0);
        wait_idle(400);
        // CS high between frames = GAP + the done cycle.
        chk("b2b_cs_gap", gap_last, D + 1);

        // Freeze for 20 cycles mid-SHIFT while reading addr 2 (0x35).
        issue(1'b0, 3'd2, 8'h00, 8'h35, 20);
        repeat (D * 6) @(negedge clk);
        ena  = 1'b0;
        snap = {busy, spi_cs_n, spi_clk, spi_mosi, rdata};
        repeat (20) @(negedge clk);
        chk("freeze_hold", {busy, spi_cs_n, spi_clk, spi_mosi, rdata}, snap);
        chk("freeze_busy", busy, 1'b1);
        chk("freeze_cs_n", spi_cs_n, 1'b0);
        ena = 1'b1;
        wait_idle(400);

        // Reset at SPI edge 10 of a mode-2 write to addr 2; then read addr 2 back.
        mode = 2'b10;
        repeat (4) @(negedge clk);
        issue(1'b1, 3'd2, 8'hC3, 8'h00, 0);
        for (int i = 0; i < 400; i++) begin
            if (sl_edges >= 10) break;
            @(negedge clk);
        end
        chk("edge10_reached", (sl_edges >= 10), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        drop_e = exp_q.pop_back();
        chk("abort_cs_n", spi_cs_n, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_spi_clk", spi_clk, 1'b0);
        chk("abort_rdata", rdata, 8'h00);
        chk("abort_done", done, 1'b0);
        rst = 1'b0;
        repeat (40 * D) @(negedge clk);
        issue(1'b0, 3'd2, 8'h00, 8'h35, 0);
        wait_idle(400);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
